// File: rtl/rom_seq_player.sv
// Address sequencer for a synchronous-read ROM; steps addr once per tick between latched start/end, one-shot or loop. Optional ping-pong via ROM_SEQ_PINGPONG_EN.
// Latency: busy one cycle after start; leds take the ROM word two edges after each addr change or load.
// Backpressure: none; a tick outside PLAY is dropped, stop beats tick, and start is ignored while playing.
module rom_seq_player #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    output logic [AW-1:0] addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] leds,
    output logic          busy,
    output logic          done
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] addr_nxt;
    logic [AW-1:0] start_q, end_q;
    logic          upd_nxt;      // addr is being loaded or changed this cycle
    logic          upd_s1;       // ROM is sampling the new addr
    logic          upd_s2;       // ROM word for the new addr is on rom_data
    logic          done_nxt;
    logic          launch;
`ifdef ROM_SEQ_PINGPONG_EN
    logic          dir_dn, dir_dn_nxt;
`endif

    assign launch = (state == IDLE) && start && !stop;
    assign busy   = (state == PLAY);

    // Next state, next address and completion pulse.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        upd_nxt   = 1'b0;
        done_nxt  = 1'b0;
`ifdef ROM_SEQ_PINGPONG_EN
        dir_dn_nxt = dir_dn;
`endif
        case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt = PLAY;
                    addr_nxt  = start_addr;
                    upd_nxt   = 1'b1;
`ifdef ROM_SEQ_PINGPONG_EN
                    dir_dn_nxt = 1'b0;
`endif
                end
            end
            PLAY: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (tick) begin
`ifdef ROM_SEQ_PINGPONG_EN
                    if (dir_dn) begin
                        if (addr != start_q) begin
                            addr_nxt = addr - 1'b1;
                            upd_nxt  = 1'b1;
                        end else if (loop) begin
                            dir_dn_nxt = 1'b0;
                            addr_nxt   = start_q + 1'b1;
                            upd_nxt    = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end
                    end else if (addr != end_q) begin
                        addr_nxt = addr + 1'b1;
                        upd_nxt  = 1'b1;
                    end else if (loop) begin
                        // A one-address sequence has nowhere to bounce to, so hold.
                        if (start_q != end_q) begin
                            dir_dn_nxt = 1'b1;
                            addr_nxt   = addr - 1'b1;
                            upd_nxt    = 1'b1;
                        end
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
`else
                    if (addr != end_q) begin
                        addr_nxt = addr + 1'b1;
                        upd_nxt  = 1'b1;
                    end else if (loop) begin
                        addr_nxt = start_q;
                        upd_nxt  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, address, latched bounds, update-flag pipeline and LED capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= '0;
            start_q <= '0;
            end_q   <= '0;
            upd_s1  <= 1'b0;
            upd_s2  <= 1'b0;
            done    <= 1'b0;
            leds    <= '0;
`ifdef ROM_SEQ_PINGPONG_EN
            dir_dn  <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            addr   <= addr_nxt;
            done   <= done_nxt;
            upd_s1 <= upd_nxt;
            upd_s2 <= upd_s1;
            if (launch) begin
                start_q <= start_addr;
                end_q   <= end_addr;
            end
            if (upd_s2) begin
                leds <= rom_data;
            end
`ifdef ROM_SEQ_PINGPONG_EN
            dir_dn <= dir_dn_nxt;
`endif
        end
    end

endmodule
